alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Shares one combinational 32-bit ALU (AND/OR/ADD/NOR/XOR/SUB/MUL, signed overflow flag) between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready request handshake and a single-entry response channel.
- Holds the ALU busy for MUL_CYCLES cycles on multiply, so the multiplier path can be timed as multicycle.
- Sits between the decode/issue stages and the shared ALU instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MUL_CYCLES, 4, cycles the ALU inputs are held for op 111 before result capture (>=1)
ID_W, $clog2(NUM_REQ) (min 1), width of the requester id

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept; at most one bit set
req_a  in  NUM_REQ*32  operand A, requester i at [32*i+:32]
req_b  in  NUM_REQ*32  operand B, same packing
req_op  in  NUM_REQ*3  opcode, requester i at [3*i+:3]
req_unsig  in  NUM_REQ  unsigned flag per requester
alu_a  out  32  latched operand A to the ALU
alu_b  out  32  latched operand B to the ALU
alu_op  out  3  latched opcode to the ALU
alu_unsig  out  1  latched unsigned flag to the ALU
alu_out  in  32  ALU result
alu_overflow  in  1  ALU overflow flag
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_id  out  ID_W  index of the requester that issued the op
resp_data  out  32  captured result
resp_overflow  out  1  captured overflow flag
resp_error  out  1  opcode was the illegal 011
busy  out  1  high in every state except IDLE

Behaviour:
- Reset state: all outputs 0 (req_ready, resp_*, alu_*, busy); FSM in IDLE; round-robin pointer 0; MUL counter 0.
- Reset asserted mid-operation abandons the op with no response.
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE, grant:
  - If any req_valid is set, the grant goes to the first valid index at or after the pointer (wrapping).
  - req_ready[g] is asserted combinationally in the same cycle; the transfer happens on that edge.
  - No grant while no valid is set.
- IDLE, on transfer:
  - Latch a, b, op, unsig and id into the operand registers; the pointer becomes (g+1) mod NUM_REQ.
  - Next state is MUL with counter = MUL_CYCLES-1 if op==111, otherwise EXEC.
- EXEC (1 cycle):
  - For op 011: resp_data = 0, resp_overflow = 0, resp_error = 1.
  - For any other op: resp_data = alu_out, resp_overflow = alu_overflow, resp_error = 0.
  - Next state is RESP.
- MUL:
  - Counter decrements each cycle.
  - In the cycle the counter is 0, capture as in EXEC, then go to RESP.
  - Total time in MUL is exactly MUL_CYCLES cycles.
- RESP:
  - resp_valid = 1; resp_* are held stable until the handshake.
  - On resp_valid & resp_ready, go to IDLE with resp_valid cleared.
- Latency, counted from the accept edge to the first resp_valid cycle:
  - Non-multiply ops: 2 cycles.
  - Multiply: MUL_CYCLES+1 cycles.
- Throughput: at most one op in flight; req_ready stays 0 outside IDLE. A new grant is possible the cycle after the response handshake.
- ALU drive: alu_a, alu_b, alu_op and alu_unsig come only from the operand registers and change only on accept. Inputs are therefore stable for the whole EXEC/MUL window.
- Data handling: alu_out and alu_overflow are passed through unmodified; the controller does no arithmetic.
- Fairness: a requester holding valid waits at most NUM_REQ-1 other grants.
- A requester may drop req_valid before a grant; nothing is latched in that case.
- Simultaneous valids in IDLE: exactly one grant, chosen by the pointer.
- resp_ready held low: the controller stalls in RESP indefinitely and all req_ready stay 0.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_AND=000, OP_OR=001, OP_ADD=010, OP_ILL=011, OP_NOR=100, OP_XOR=101, OP_SUB=110, OP_MUL=111;
  - the FSM state encoding (IDLE, EXEC, MUL, RESP).
- One sub-module, rr_arbiter (NUM_REQ):
  - inputs: request vector, pointer, enable;
  - output: one-hot grant plus encoded index.
- The FSM, operand and result registers stay in alu_share_ctrl.

Test Plan:
- Req0 ADD a=7, b=5, resp_ready=1 -> accept at cycle 0; resp_valid at cycle 2 with resp_data=12, resp_overflow=0, resp_id=0.
- Req1 SUB a=0x8000_0000, b=1 -> resp_data=0x7FFF_FFFF, resp_overflow=1, resp_id=1.
- Req0 MUL a=3, b=-2 with MUL_CYCLES=4 -> alu_* stable for 4 cycles; resp_valid at cycle 5 with resp_data=0xFFFF_FFFA, overflow=0.
- Both requesters hold valid continuously for 4 ops -> grant order 0,1,0,1; req_ready never has two bits set.
- Op 011 -> resp_error=1, resp_data=0. Then resp_ready held low for 10 cycles -> resp_* stable, req_ready=0, busy=1.
- reset asserted during MUL -> next cycle state IDLE, resp_valid=0, busy=0, and no response is ever produced for the abandoned op.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and controller state encoding shared by the
// ALU sharing controller, its arbiter and anything that decodes alu_op.
//   OP_*     : 3-bit ALU opcodes (OP_ILL is reserved and never executed)
//   state_t  : controller FSM states
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_ILL = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin grant over NUM_REQ requesters.
//   req        in  NUM_REQ  request vector
//   ptr        in  ID_W     highest-priority index this cycle
//   en         in  1        arbitration enable; no grant while low
//   grant      out NUM_REQ  one-hot grant (all zero when nothing granted)
//   grant_idx  out ID_W     encoded index of the granted requester
//   grant_vld  out 1        a grant is being issued
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter import alu_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_vld
);

    int idx;

    // Scan from ptr upward with wrap; the first set request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (en && !grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational 32-bit ALU between NUM_REQ
// requesters, one operation in flight at a time.
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     per-requester request handshake (ready one-hot)
//   req_a/req_b/req_op/req_unsig  packed per-requester operands
//   alu_a/alu_b/alu_op/alu_unsig  registered operands to the shared ALU
//   alu_out/alu_overflow    ALU result, passed through unmodified
//   resp_valid/resp_ready   single-entry response handshake
//   resp_id/resp_data/resp_overflow/resp_error  captured response
//   busy                    high in every state except IDLE
//   dbg_state               current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters may drop valid before ready; the response side holds
// resp_valid and all resp_* stable until resp_ready is seen.
// Multiply holds the ALU operands for MUL_CYCLES cycles so the multiplier
// path can be constrained as a multicycle path.
module alu_share_ctrl import alu_pkg::*; #(
    parameter int NUM_REQ    = 2,
    parameter int MUL_CYCLES = 4,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]  req_op,
    input  logic [NUM_REQ-1:0]    req_unsig,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [2:0]            alu_op,
    output logic                  alu_unsig,
    input  logic [31:0]           alu_out,
    input  logic                  alu_overflow,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    output logic                  resp_overflow,
    output logic                  resp_error,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Counter only needs to hold MUL_CYCLES-1.
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   mul_cnt, mul_cnt_nxt;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    op_id;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;
    logic [2:0]         sel_op;
    logic               capture;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .en        (state == ST_IDLE),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign req_ready  = grant;
    assign sel_op     = req_op[3*grant_idx +: 3];
    assign resp_valid = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);
    assign dbg_state  = state;

    always_comb begin
        state_nxt   = state;
        mul_cnt_nxt = mul_cnt;
        capture     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_vld) begin
                    if (sel_op == OP_MUL) begin
                        state_nxt   = ST_MUL;
                        mul_cnt_nxt = CNT_W'(MUL_CYCLES - 1);
                    end else begin
                        state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                capture   = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_MUL: begin
                // Capture in the last of the MUL_CYCLES held cycles.
                if (mul_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    mul_cnt_nxt = mul_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            mul_cnt       <= '0;
            ptr           <= '0;
            op_id         <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= '0;
            alu_unsig     <= 1'b0;
            resp_id       <= '0;
            resp_data     <= '0;
            resp_overflow <= 1'b0;
            resp_error    <= 1'b0;
        end else begin
            state   <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
            if (grant_vld) begin
                alu_a     <= req_a[32*grant_idx +: 32];
                alu_b     <= req_b[32*grant_idx +: 32];
                alu_op    <= sel_op;
                alu_unsig <= req_unsig[grant_idx];
                op_id     <= grant_idx;
                ptr       <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (capture) begin
                resp_id <= op_id;
                // The reserved opcode is reported as an error; whatever the
                // ALU drives for it is discarded.
                if (alu_op == OP_ILL) begin
                    resp_data     <= '0;
                    resp_overflow <= 1'b0;
                    resp_error    <= 1'b1;
                end else begin
                    resp_data     <= alu_out;
                    resp_overflow <= alu_overflow;
                    resp_error    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: bench for alu_share_ctrl with NUM_REQ=2, MUL_CYCLES=4.
// A behavioural ALU sits on the alu_* port; responses are scoreboarded
// against results computed from the operands driven by each requester.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int NUM_REQ    = 2;
  localparam int MUL_CYCLES = 4;
  localparam int ID_W       = 1;
  localparam int W          = ID_W + 34;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic [NUM_REQ-1:0]    v;
  logic [31:0]           a [NUM_REQ];
  logic [31:0]           b [NUM_REQ];
  logic [2:0]            op [NUM_REQ];
  logic [NUM_REQ-1:0]    u;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           alu_a, alu_b, alu_out;
  logic [2:0]            alu_op;
  logic                  alu_unsig, alu_overflow;
  logic                  resp_valid, resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_data;
  logic                  resp_overflow, resp_error, busy;
  logic [1:0]            dbg_state;

  alu_share_ctrl #(
    .NUM_REQ    (NUM_REQ),
    .MUL_CYCLES (MUL_CYCLES),
    .ID_W       (ID_W)
  ) dut (
    .clock         (clk),
    .reset         (reset),
    .req_valid     (v),
    .req_ready     (req_ready),
    .req_a         ({a[1], a[0]}),
    .req_b         ({b[1], b[0]}),
    .req_op        ({op[1], op[0]}),
    .req_unsig     (u),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_unsig     (alu_unsig),
    .alu_out       (alu_out),
    .alu_overflow  (alu_overflow),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_data     (resp_data),
    .resp_overflow (resp_overflow),
    .resp_error    (resp_error),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- behavioural ALU ----------------
  function automatic logic [32:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] o, input logic us);
    logic [31:0]        r;
    logic               ov;
    logic signed [63:0] ps;
    logic [63:0]        pu;
    r  = '0;
    ov = 1'b0;
    case (o)
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_ADD: begin
        r  = x + y;
        ov = !us && (x[31] == y[31]) && (r[31] != x[31]);
      end
      OP_ILL: begin
        r  = 32'hDEAD_BEEF;
        ov = 1'b1;
      end
      OP_NOR: r = ~(x | y);
      OP_XOR: r = x ^ y;
      OP_SUB: begin
        r  = x - y;
        ov = !us && (x[31] != y[31]) && (r[31] != x[31]);
      end
      default: begin
        if (us) begin
          pu = {32'b0, x} * {32'b0, y};
          r  = pu[31:0];
          ov = |pu[63:32];
        end else begin
          ps = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
          r  = ps[31:0];
          ov = (ps[63:32] != {32{ps[31]}});
        end
      end
    endcase
    return {ov, r};
  endfunction

  always_comb {alu_overflow, alu_out} = alu_model(alu_a, alu_b, alu_op, alu_unsig);

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           rr_ptr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] expect_resp(input int g);
    logic [32:0] m;
    m = alu_model(a[g], b[g], op[g], u[g]);
    if (op[g] == OP_ILL) return {ID_W'(g), 1'b1, 1'b0, 32'h0};
    return {ID_W'(g), 1'b0, m[32], m[31:0]};
  endfunction

  // Response monitor, sampling on the falling edge.
  logic         prev_rv = 1'b0;
  logic [W-1:0] prev_resp = '0;
  logic [W-1:0] e;
  always @(negedge clk) begin
    if (reset) begin
      prev_rv = 1'b0;
    end else begin
      check("ready_onehot", $onehot0(req_ready), 1);
      if (busy) check("ready_while_busy", req_ready, 0);
      if (resp_valid && !prev_rv) begin
        if (lat_q.size() == 0) check("resp_without_op", resp_valid, 0);
        else check("latency", cyc, lat_q.pop_front());
      end
      if (resp_valid && prev_rv)
        check("resp_stable", {resp_id, resp_error, resp_overflow, resp_data}, prev_resp);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("resp_without_op", resp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("resp", {resp_id, resp_error, resp_overflow, resp_data}, e);
        end
      end
      prev_rv   = resp_valid && !resp_ready;
      prev_resp = {resp_id, resp_error, resp_overflow, resp_data};
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for a grant to a valid requester, scoreboards it, and returns
  // just after the transfer edge.
  task automatic wait_accept(output int g);
    int exp_g;
    g = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((req_ready & v) != 0) begin
        g = req_ready[1] ? 1 : 0;
        exp_g = v[rr_ptr] ? rr_ptr : (rr_ptr + 1) % NUM_REQ;
        check("grant_rr", g, exp_g);
        exp_q.push_back(expect_resp(g));
        lat_q.push_back(cyc + ((op[g] == OP_MUL) ? MUL_CYCLES + 1 : 2));
        rr_ptr = (g + 1) % NUM_REQ;
        @(posedge clk);
        #1;
        return;
      end
    end
    check("accept_timeout", (req_ready & v) != 0, 1);
  endtask

  task automatic issue(input int r, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [2:0] xo, input logic xu, output int g);
    @(posedge clk);
    #1;
    a[r] = xa; b[r] = xb; op[r] = xo; u[r] = xu;
    v[r] = 1'b1;
    wait_accept(g);
    v[r] = 1'b0;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_valid) return;
    end
    check("resp_timeout", resp_valid, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && lat_q.size() == 0 && !busy) return;
    end
    check("drain_timeout", busy, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int g;
    int n_done [NUM_REQ];
    v = '0; u = '0; resp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      a[i] = '0; b[i] = '0; op[i] = '0; n_done[i] = 0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_resp", {resp_valid, resp_id, resp_error, resp_overflow, resp_data}, 0);
    check("rst_alu", {alu_a, alu_b, alu_op, alu_unsig}, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;

    // ADD 7+5 from requester 0.
    issue(0, 32'd7, 32'd5, OP_ADD, 1'b0, g);
    wait_resp();
    check("add_data", {resp_id, resp_overflow, resp_data}, {1'b0, 1'b0, 32'd12});
    drain();

    // SUB with signed overflow from requester 1.
    issue(1, 32'h8000_0000, 32'd1, OP_SUB, 1'b0, g);
    wait_resp();
    check("sub_data", {resp_id, resp_overflow, resp_data}, {1'b1, 1'b1, 32'h7FFF_FFFF});
    drain();

    // Both requesters continuously valid: alternating grants 0,1,0,1.
    @(posedge clk);
    #1;
    for (int r = 0; r < NUM_REQ; r++) begin
      a[r] = $urandom; b[r] = $urandom;
      op[r] = 3'($urandom_range(0, 7)); u[r] = 1'($urandom_range(0, 1));
    end
    v = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_accept(g);
      check("fair_order", g, k % 2);
      if (g >= 0) begin
        n_done[g]++;
        if (n_done[g] == 2) begin
          v[g] = 1'b0;
        end else begin
          a[g] = $urandom; b[g] = $urandom;
          op[g] = 3'($urandom_range(0, 7)); u[g] = 1'($urandom_range(0, 1));
        end
      end
    end
    v = '0;
    drain();

    // Multiply 3 * -2: operands held for the whole MUL window.
    issue(0, 32'd3, 32'hFFFF_FFFE, OP_MUL, 1'b0, g);
    for (int i = 0; i < MUL_CYCLES; i++) begin
      @(negedge clk);
      check("mul_alu_hold", {alu_a, alu_b, alu_op}, {32'd3, 32'hFFFF_FFFE, OP_MUL});
      check("mul_state", dbg_state, ST_MUL);
    end
    wait_resp();
    check("mul_data", {resp_overflow, resp_data}, {1'b0, 32'hFFFF_FFFA});
    drain();

    // Random single operations.
    for (int k = 0; k < 8; k++) begin
      issue(int'($urandom_range(0, 1)), $urandom, $urandom,
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), g);
      drain();
    end

    // Illegal opcode, then response stalled for 10 cycles.
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    issue(1, 32'h1234_5678, 32'h0F0F_0F0F, OP_ILL, 1'b0, g);
    wait_resp();
    check("ill_resp", {resp_id, resp_error, resp_overflow, resp_data}, {1'b1, 1'b1, 1'b0, 32'h0});
    a[0] = 32'd100; b[0] = 32'd23; op[0] = OP_ADD; u[0] = 1'b0;
    v[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold", {resp_valid, resp_id, resp_error, resp_data}, {1'b1, 1'b1, 1'b1, 32'h0});
      check("stall_ready", req_ready, 0);
      check("stall_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    wait_accept(g);
    check("post_stall_grant", g, 0);
    v[0] = 1'b0;
    drain();

    // Reset during MUL abandons the op.
    issue(0, 32'd9, 32'd9, OP_MUL, 1'b0, g);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    lat_q.delete();
    rr_ptr = 0;
    @(negedge clk);
    check("rst_mid_state", dbg_state, ST_IDLE);
    check("rst_mid_resp", resp_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_alu", {alu_a, alu_op}, 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_mid_no_resp", resp_valid, 0);

    // Recovery after reset: requester 1 alone, XOR.
    issue(1, 32'hFF00_FF00, 32'h0FF0_0FF0, OP_XOR, 1'b1, g);
    wait_resp();
    check("xor_data", {resp_id, resp_data}, {1'b1, 32'hF0F0_F0F0});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
